// File: rtl/voice_allocator_pkg.sv
// Shared types and default sizing for the voice allocator and its free-voice picker.
package voice_allocator_pkg;

  localparam int DEF_NUM_VOICES = 3;
  localparam int DEF_NOTE_W     = 6;
  localparam int DEF_DUR_W      = 6;
  localparam int LOAD_CNT_W     = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  // Index width that stays at least one bit wide for a single-voice build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_free_picker.sv
// Combinational rotating first-free search: lowest busy==0 voice at or above start_ptr, wrapping.
module rr_free_picker
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int IDX_W      = idx_width(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0] busy,
  input  logic [IDX_W-1:0]      start_ptr,
  output logic [IDX_W-1:0]      pick_idx,
  output logic                  found
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] cand_s;

  // Walk offsets from the far end down so the nearest free voice is the last one written.
  always_comb begin
    pick_idx = {IDX_W{1'b0}};
    found    = 1'b0;
    cand_s   = {SUM_W{1'b0}};
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      cand_s = {1'b0, start_ptr} + SUM_W'(i);
      if (cand_s >= SUM_W'(NUM_VOICES)) begin
        cand_s = cand_s - SUM_W'(NUM_VOICES);
      end else begin
        cand_s = cand_s;
      end
      if (busy[cand_s[IDX_W-1:0]] == 1'b0) begin
        found    = 1'b1;
        pick_idx = cand_s[IDX_W-1:0];
      end else begin
        found    = found;
        pick_idx = pick_idx;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Hands incoming note requests to free note_player voices, one load strobe per accepted request.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_W     = DEF_NOTE_W,
  parameter int DUR_W      = DEF_DUR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [NOTE_W-1:0]            req_note,
  input  logic [DUR_W-1:0]             req_dur,
  output logic [NUM_VOICES*NOTE_W-1:0] notes_to_load,
  output logic [NUM_VOICES*DUR_W-1:0]  durs_to_load,
  output logic [NUM_VOICES-1:0]        notes_load,
  input  logic [NUM_VOICES-1:0]        notes_done,
  output logic [NUM_VOICES-1:0]        voice_busy,
  output logic                         all_idle,
  output logic [LOAD_CNT_W-1:0]        load_count
);

  localparam int IDX_W = idx_width(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t                       state_r;
  state_t                       state_next_s;
  logic [IDX_W-1:0]             rr_ptr_r;
  logic [IDX_W-1:0]             voice_r;
  logic [NUM_VOICES-1:0]        busy_r;
  logic [NUM_VOICES-1:0]        busy_set_s;
  logic [NUM_VOICES-1:0]        busy_next_s;
  logic [NUM_VOICES-1:0]        strobe_r;
  logic [NUM_VOICES-1:0]        strobe_next_s;
  logic [NUM_VOICES*NOTE_W-1:0] notes_r;
  logic [NUM_VOICES*DUR_W-1:0]  durs_r;
  logic [LOAD_CNT_W-1:0]        count_r;
  logic [IDX_W-1:0]             pick_idx_s;
  logic                         found_s;
  logic                         load_s;

  rr_free_picker #(
    .NUM_VOICES (NUM_VOICES),
    .IDX_W      (IDX_W)
  ) u_picker (
    .busy      (busy_r),
    .start_ptr (rr_ptr_r),
    .pick_idx  (pick_idx_s),
    .found     (found_s)
  );

  // A zero-duration request is consumed but never reaches a voice.
  assign load_s = req_valid && req_ready && (req_dur != {DUR_W{1'b0}});

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    if (flush) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = load_s ? ST_ISSUE : ST_IDLE;
        ST_ISSUE: state_next_s = ST_IDLE;
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // FSM outputs; a flush landing in ISSUE kills the strobe already queued for that cycle.
  always_comb begin
    req_ready  = 1'b0;
    all_idle   = 1'b0;
    notes_load = {NUM_VOICES{1'b0}};
    if (reset && (state_r == ST_IDLE) && !flush && found_s) begin
      req_ready = 1'b1;
    end else begin
      req_ready = 1'b0;
    end
    if ((busy_r == {NUM_VOICES{1'b0}}) && (state_r == ST_IDLE)) begin
      all_idle = 1'b1;
    end else begin
      all_idle = 1'b0;
    end
    if (flush) begin
      notes_load = {NUM_VOICES{1'b0}};
    end else begin
      notes_load = strobe_r;
    end
  end

  // Busy is claimed at accept and re-asserted during the strobe so a same-cycle done cannot clear it.
  always_comb begin
    busy_set_s    = {NUM_VOICES{1'b0}};
    strobe_next_s = {NUM_VOICES{1'b0}};
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (load_s && (pick_idx_s == IDX_W'(v))) begin
        busy_set_s[v]    = 1'b1;
        strobe_next_s[v] = 1'b1;
      end else if ((state_r == ST_ISSUE) && (voice_r == IDX_W'(v))) begin
        busy_set_s[v] = 1'b1;
      end else begin
        busy_set_s[v] = 1'b0;
      end
    end
    busy_next_s = (busy_r & ~notes_done) | busy_set_s;
  end

  // Voice bookkeeping, slot capture and load counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r <= {IDX_W{1'b0}};
      voice_r  <= {IDX_W{1'b0}};
      busy_r   <= {NUM_VOICES{1'b0}};
      strobe_r <= {NUM_VOICES{1'b0}};
      notes_r  <= {(NUM_VOICES*NOTE_W){1'b0}};
      durs_r   <= {(NUM_VOICES*DUR_W){1'b0}};
      count_r  <= {LOAD_CNT_W{1'b0}};
    end else if (flush) begin
      rr_ptr_r <= {IDX_W{1'b0}};
      busy_r   <= {NUM_VOICES{1'b0}};
      strobe_r <= {NUM_VOICES{1'b0}};
    end else begin
      busy_r   <= busy_next_s;
      strobe_r <= strobe_next_s;
      if (load_s) begin
        voice_r <= pick_idx_s;
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (load_s && (pick_idx_s == IDX_W'(v))) begin
          notes_r[v*NOTE_W +: NOTE_W] <= req_note;
          durs_r[v*DUR_W +: DUR_W]    <= req_dur;
        end
      end
      if (state_r == ST_ISSUE) begin
        rr_ptr_r <= (voice_r == LAST_IDX) ? {IDX_W{1'b0}} : voice_r + IDX_W'(1);
        if (count_r != {LOAD_CNT_W{1'b1}}) begin
          count_r <= count_r + LOAD_CNT_W'(1);
        end
      end
    end
  end

  assign notes_to_load = notes_r;
  assign durs_to_load  = durs_r;
  assign voice_busy    = busy_r;
  assign load_count    = count_r;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: expected loads are queued at accept and matched against strobes.
module tb_voice_allocator;

  localparam int NV = 3;
  localparam int NW = 6;
  localparam int DW = 6;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [NW-1:0]   req_note = '0;
  logic [DW-1:0]   req_dur = '0;
  logic [NV*NW-1:0] notes_to_load;
  logic [NV*DW-1:0] durs_to_load;
  logic [NV-1:0]   notes_load;
  logic [NV-1:0]   notes_done = '0;
  logic [NV-1:0]   voice_busy;
  logic            all_idle;
  logic [15:0]     load_count;

  typedef struct {
    int voice;
    int note;
    int dur;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   strobes = 0;
  int   cyc = 0;
  int   a0, a1, a2, ax;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_note      (req_note),
    .req_dur       (req_dur),
    .notes_to_load (notes_to_load),
    .durs_to_load  (durs_to_load),
    .notes_load    (notes_load),
    .notes_done    (notes_done),
    .voice_busy    (voice_busy),
    .all_idle      (all_idle),
    .load_count    (load_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] note_slot(input int v);
    return 32'(notes_to_load[v*NW +: NW]);
  endfunction

  function automatic logic [31:0] dur_slot(input int v);
    return 32'(durs_to_load[v*DW +: DW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait (bounded) for ready, then let one edge accept it.
  task automatic send(input int note, input int dur, input int voice, input bit expect_load,
                      output int acc_cyc);
    int n = 0;
    req_note  = NW'(note);
    req_dur   = DW'(dur);
    req_valid = 1'b1;
    #1;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      check_val("ready_timeout", 32'(req_ready), 32'd1);
      acc_cyc   = -1;
      req_valid = 1'b0;
    end else begin
      acc_cyc = cyc + 1;
      if (expect_load) sb_q.push_back('{voice, note, dur, cyc + 1});
      tick();
      req_valid = 1'b0;
    end
  endtask

  // Strobe monitor: every strobe must match the oldest queued expectation.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (notes_load != '0) begin
        strobes++;
        if (sb_q.size() == 0) begin
          check_val("unexpected_strobe", 32'(notes_load), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check_val("strobe_voice", 32'(notes_load), 32'd1 << e.voice);
          check_val("strobe_cycle", 32'(cyc), 32'(e.cyc));
          check_val("slot_note", note_slot(e.voice), 32'(e.note));
          check_val("slot_dur", dur_slot(e.voice), 32'(e.dur));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_all_idle", 32'(all_idle), 32'd1);
    check_val("rst_busy", 32'(voice_busy), 32'd0);
    check_val("rst_load", 32'(notes_load), 32'd0);
    check_val("rst_count", 32'(load_count), 32'd0);
    check_val("rst_notes", 32'(notes_to_load), 32'd0);
    tick();
    tick();
    check_val("rst_ready_held", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #1;
    check_val("post_rst_ready", 32'(req_ready), 32'd1);

    // Three back-to-back loads fill voices 0,1,2.
    send(10, 4, 0, 1'b1, a0);
    send(12, 4, 1, 1'b1, a1);
    send(14, 4, 2, 1'b1, a2);
    tick();
    check_val("b2b_gap01", 32'(a1 - a0), 32'd2);
    check_val("b2b_gap12", 32'(a2 - a1), 32'd2);
    check_val("full_busy", 32'(voice_busy), 32'd7);
    check_val("full_ready", 32'(req_ready), 32'd0);
    check_val("full_all_idle", 32'(all_idle), 32'd0);
    check_val("count3", 32'(load_count), 32'd3);

    // Held request while full; voice 1 frees and takes it.
    req_note = 6'd20; req_dur = 6'd5; req_valid = 1'b1;
    tick();
    tick();
    check_val("held_ready", 32'(req_ready), 32'd0);
    notes_done = 3'b010;
    #1;
    check_val("done_cycle_ready", 32'(req_ready), 32'd0);
    tick();
    notes_done = 3'b000;
    #1;
    check_val("freed_ready", 32'(req_ready), 32'd1);
    sb_q.push_back('{1, 20, 5, cyc + 1});
    tick();
    req_valid = 1'b0;
    tick();
    check_val("count4", 32'(load_count), 32'd4);

    // Zero-duration request is swallowed without a load.
    notes_done = 3'b001;
    tick();
    notes_done = 3'b000;
    send(33, 0, 0, 1'b0, ax);
    check_val("dur0_ready", 32'(req_ready), 32'd1);
    tick();
    tick();
    check_val("dur0_busy", 32'(voice_busy), 32'd6);
    check_val("dur0_count", 32'(load_count), 32'd4);
    check_val("dur0_strobes", 32'(strobes), 32'd4);

    // Done on voice 0 in its own strobe cycle: the load wins.
    send(40, 7, 0, 1'b1, ax);
    notes_done = 3'b001;
    tick();
    notes_done = 3'b000;
    #1;
    check_val("load_wins_busy", 32'(voice_busy), 32'd7);

    // Flush during ISSUE suppresses the strobe but keeps slots and count.
    notes_done = 3'b100;
    tick();
    notes_done = 3'b000;
    send(50, 9, 2, 1'b0, ax);
    flush = 1'b1;
    #1;
    check_val("flush_no_strobe", 32'(notes_load), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check_val("flush_busy", 32'(voice_busy), 32'd0);
    check_val("flush_all_idle", 32'(all_idle), 32'd1);
    check_val("flush_count", 32'(load_count), 32'd5);
    check_val("flush_slot2_note", note_slot(2), 32'd50);
    check_val("flush_slot2_dur", dur_slot(2), 32'd9);
    check_val("flush_slot0_note", note_slot(0), 32'd40);
    check_val("flush_slot1_note", note_slot(1), 32'd20);
    send(60, 3, 0, 1'b1, ax);
    tick();
    check_val("count6", 32'(load_count), 32'd6);

    // Reset in the middle of an ISSUE cycle.
    send(61, 2, 1, 1'b0, ax);
    reset = 1'b0;
    #1;
    check_val("midrst_load", 32'(notes_load), 32'd0);
    check_val("midrst_busy", 32'(voice_busy), 32'd0);
    check_val("midrst_count", 32'(load_count), 32'd0);
    check_val("midrst_ready", 32'(req_ready), 32'd0);
    check_val("midrst_all_idle", 32'(all_idle), 32'd1);
    check_val("midrst_notes", 32'(notes_to_load), 32'd0);
    tick();
    reset = 1'b1;
    send(62, 4, 0, 1'b1, ax);
    tick();
    tick();
    check_val("final_count", 32'(load_count), 32'd1);
    check_val("final_strobes", 32'(strobes), 32'd7);
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 Parameter NUM_VOICES, default 3: number of note_player voices served.
REQ-002 Parameter NOTE_W, default 6: note code width.
REQ-003 Parameter DUR_W, default 6: duration width, in beats.
REQ-004 Port clk, input, 1: single system clock; all logic is rising-edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port flush, input, 1: synchronous clear on song change or player reset.
REQ-007 Port req_valid, input, 1: a note request is present.
REQ-008 Port req_ready, output, 1: the block accepts the request this cycle.
REQ-009 Port req_note, input, NOTE_W: note code of the request.
REQ-010 Port req_dur, input, DUR_W: duration of the request.
REQ-011 Port notes_to_load, output, NUM_VOICES*NOTE_W: per-voice note slots; voice v occupies bits [v*NOTE_W +: NOTE_W].
REQ-012 Port durs_to_load, output, NUM_VOICES*DUR_W: per-voice duration slots, packed like notes_to_load.
REQ-013 Port notes_load, output, NUM_VOICES: one-cycle load strobe per voice.
REQ-014 Port notes_done, input, NUM_VOICES: one-cycle done pulse from each voice.
REQ-015 Port voice_busy, output, NUM_VOICES: the voice currently holds a note.
REQ-016 Port all_idle, output, 1: no voice is busy and no load is pending.
REQ-017 Port load_count, output, 16: saturating count of issued loads.

Function
REQ-018 The FSM SHALL have two states, IDLE and ISSUE.
REQ-019 req_ready SHALL be 1 only when state is IDLE, flush=0, and at least one voice_busy bit is 0.
REQ-020 A request is accepted when req_valid=1 and req_ready=1.
REQ-021 If an accepted request has req_dur=0, it SHALL be discarded: no voice change, state stays IDLE.
REQ-022 Otherwise, the block SHALL select the first free voice, searching upward modulo NUM_VOICES from rr_ptr.
REQ-023 On the same accept cycle, it SHALL latch req_note and req_dur into that voice's slot and enter ISSUE.
REQ-024 In ISSUE, notes_load[v] SHALL be 1 for exactly one cycle, one cycle after accept.
REQ-025 In ISSUE, voice_busy[v] SHALL set in the same cycle as the strobe.
REQ-026 In ISSUE, rr_ptr SHALL become (v+1) mod NUM_VOICES, and load_count SHALL increment, saturating at 16'hFFFF.
REQ-027 The FSM SHALL return to IDLE after ISSUE; maximum throughput is one load every 2 cycles.
REQ-028 Slot contents SHALL hold until that voice is next loaded; other voices' slots are never disturbed.
REQ-029 notes_done[v]=1 SHALL clear voice_busy[v] on the next edge.
REQ-030 A done pulse on a non-busy voice SHALL be ignored.
REQ-031 The free search SHALL use registered voice_busy, so a voice finishing this cycle is not selectable until the next cycle.
REQ-032 If a strobe and a done pulse hit the same voice in the same cycle, busy SHALL end at 1 (the load wins).
REQ-033 When all voices are busy, req_ready SHALL be 0 and the request SHALL be held without loss until a voice frees.
REQ-034 all_idle SHALL equal (voice_busy==0) and (state==IDLE).
REQ-035 flush=1 SHALL clear voice_busy and rr_ptr on the next edge, force IDLE, and suppress any pending strobe.
REQ-036 flush SHALL preserve slot contents and load_count.

Reset
REQ-037 While reset=0: state=IDLE, rr_ptr=0, voice_busy=0, notes_load=0, slots=0, load_count=0.
REQ-038 While reset=0: req_ready=0 and all_idle=1.
REQ-039 Reset asserted mid-ISSUE SHALL abort the strobe immediately.
REQ-040 Release of reset SHALL take effect at the first clk edge after reset goes high.

Structure
REQ-041 A shared package SHALL hold the FSM state encoding and the default NUM_VOICES, NOTE_W and DUR_W constants.
REQ-042 The rotating first-free search SHALL be a sub-module named rr_free_picker.
REQ-043 rr_free_picker SHALL be purely combinational: inputs busy mask and start pointer; outputs index and found.

Verification
REQ-044 Reset release, then requests (note 6'd10, dur 4), (6'd12, 4), (6'd14, 4) back-to-back: strobes on voices 0, 1, 2 at cycles +1, +3, +5; voice_busy=3'b111; req_ready=0.
REQ-045 All voices busy, req_valid held, notes_done=3'b010 for one cycle: req_ready rises the next cycle; the request loads voice 1.
REQ-046 Request with dur 0: accepted in one cycle; no strobe; voice_busy and load_count unchanged.
REQ-047 notes_done[0] in the same cycle as voice 0's strobe: voice_busy[0]=1 afterwards.
REQ-048 flush asserted in ISSUE: no strobe; voice_busy=0; rr_ptr=0; all_idle=1 the next cycle; slots unchanged.
REQ-049 reset pulled low mid-sequence: all outputs go to reset values without waiting for a clock; load_count=0.
